multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the RV32I core. Each instruction is handled in order: fetch, decode, execute, memory access and writeback.
- Fetches each instruction over a req/ack instruction-memory handshake and presents it to instruction_decoder.
- Latches the decoder control flags (alu_op, reg_write, mem_read, mem_write, branch) and uses them to drive the data-memory handshake, register-file write enable and PC update.
- Sits between the memory interfaces and the decoder/ALU/register-file datapath.

Parameters:
- XLEN, 32, datapath and PC width
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  XLEN  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction word
- instruction  out  32  latched IR, drives decoder
- alu_op  in  4  decoder output
- reg_write  in  1  decoder output
- mem_read  in  1  decoder output
- mem_write  in  1  decoder output
- branch  in  1  decoder output
- alu_op_q  out  4  latched alu_op, drives ALU
- branch_taken  in  1  ALU branch-condition result, sampled in EXEC
- branch_target  in  XLEN  computed branch/jump target, sampled in EXEC
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_ack  in  1  data access complete
- rf_we  out  1  register-file write enable, 1-cycle pulse
- pc  out  XLEN  current program counter
- state  out  3  current FSM state
- illegal  out  1  sticky illegal-opcode flag
- retired  out  32  retired-instruction counter

Behaviour:
- Reset (rst_n=0, async): state=IDLE, pc=RESET_PC, IR=0, alu_op_q=0, latched flags=0, retired=0, illegal=0. All req/we outputs are 0.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- IDLE: unconditional transition to FETCH on the next edge.
- FETCH: imem_req=1 and imem_addr=pc, held stable until ack.
  - On imem_ack=1: IR<=imem_rdata, go to DECODE.
  - Ack in the first FETCH cycle is legal (zero wait).
- DECODE: one cycle; latches alu_op, reg_write, mem_read, mem_write and branch.
  - Legal opcodes IR[6:0]: 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 1101111.
  - Any other opcode -> TRAP. Otherwise -> EXEC.
- EXEC: one cycle, priority order:
  1. jal (1101111): pc<=branch_target, go to WB.
  2. branch: pc<=branch_taken ? branch_target : pc+4, retired++, go to FETCH.
  3. mem_read or mem_write: go to MEM.
  4. reg_write: go to WB.
  5. Otherwise: pc<=pc+4, retired++, go to FETCH.
- MEM: dmem_req=1, dmem_we=mem_write_q; held stable until dmem_ack.
  - On ack with a load: go to WB.
  - On ack with a store: pc<=pc+4, retired++, go to FETCH.
- WB: rf_we=1 for exactly this cycle; retired++, go to FETCH.
  - pc<=pc+4, except for jal, where pc was already updated in EXEC.
- TRAP: illegal=1, all requests 0, pc frozen. Only reset exits this state.
- Arithmetic: pc+4 wraps modulo 2^XLEN; retired wraps at 2^32.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.
- Reset mid-handshake: outstanding request dropped immediately; restart from IDLE at RESET_PC.
- Cycles per instruction with zero-wait memory:
  - R/I-ALU, LUI: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - JAL: 4
- Each wait state adds one cycle.

Test Plan:
- Reset release, imem_ack tied 1, ADD (32'h002081B3) -> state sequence 0,1,2,3,5; rf_we high 1 cycle in WB; pc 0->4; retired=1.
- LW (32'h0040A183), dmem_ack delayed 3 cycles -> dmem_req=1 and dmem_we=0 held 4 cycles; then WB with rf_we pulse; pc=4; 8 cycles total.
- SW (32'h0030A223) -> dmem_we=1 during MEM; no rf_we; pc+4.
- BEQ with branch_taken=1, branch_target=32'h40 -> pc=32'h40 after EXEC; no WB. Repeat with branch_taken=0 -> pc=4.
- JAL, branch_target=32'h100 -> rf_we pulse in WB, pc=32'h100 (not 32'h104).
- Opcode 1111111 -> TRAP, illegal=1 and sticky, imem_req stays 0; async rst_n pulse mid-FETCH -> state=0, pc=RESET_PC, illegal=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: in-order multi-cycle sequencer for an RV32I core.
//
// Each instruction walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB). The
// instruction is fetched over a req/ack handshake, held in the IR for the
// external decoder, and the decoder's control flags are captured in DECODE
// so that EXEC/MEM/WB see stable values.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   imem_req/imem_addr/imem_ack/imem_rdata   instruction fetch handshake
//   instruction                      latched IR, feeds the decoder
//   alu_op/reg_write/mem_read/mem_write/branch   decoder outputs
//   alu_op_q                         latched alu_op, feeds the ALU
//   branch_taken/branch_target       ALU results, sampled in EXEC
//   dmem_req/dmem_we/dmem_ack        data memory handshake
//   rf_we                            register-file write pulse (WB)
//   pc, state, illegal, retired      status / debug
//
// Handshake rule (both memories): the request is a level held high with a
// stable address/direction for every cycle of the access; the access
// completes on the first rising edge where the matching ack is 1. Acks
// arriving while the request is low are ignored.
module multicycle_ctrl #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction,
  input  logic [3:0]      alu_op,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            branch,
  output logic [3:0]      alu_op_q,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [XLEN-1:0] pc,
  output logic [2:0]      state,
  output logic            illegal,
  output logic [31:0]     retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;
  logic [3:0]      alu_op_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            branch_q, branch_d;
  logic            illegal_q, illegal_d;
  logic [31:0]     retired_q, retired_d;

  logic [XLEN-1:0] pc_plus4;
  logic [6:0]      opcode;
  logic            opcode_legal;
  logic            is_jal;

  assign pc_plus4 = pc_q + XLEN'(4);
  assign opcode   = ir_q[6:0];
  assign is_jal   = (opcode == OP_JAL);

  always_comb begin
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_LUI, OP_JAL: opcode_legal = 1'b1;
      default:                                            opcode_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    alu_op_d    = alu_op_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    branch_d    = branch_q;
    illegal_d   = illegal_q;
    retired_d   = retired_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        alu_op_d    = alu_op;
        reg_write_d = reg_write;
        mem_read_d  = mem_read;
        mem_write_d = mem_write;
        branch_d    = branch;
        if (opcode_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end

      S_EXEC: begin
        // jal is checked on the opcode first: the decoder also raises
        // reg_write for it, but its PC update must happen here.
        if (is_jal) begin
          pc_d    = branch_target;
          state_d = S_WB;
        end else if (branch_q) begin
          pc_d      = branch_taken ? branch_target : pc_plus4;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end else if (mem_read_q || mem_write_q) begin
          state_d = S_MEM;
        end else if (reg_write_q) begin
          state_d = S_WB;
        end else begin
          pc_d      = pc_plus4;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write_q;
        if (dmem_ack) begin
          if (mem_write_q) begin
            pc_d      = pc_plus4;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end

      S_WB: begin
        rf_we     = 1'b1;
        retired_d = retired_q + 32'd1;
        if (!is_jal) pc_d = pc_plus4;
        state_d   = S_FETCH;
      end

      S_TRAP: state_d = S_TRAP;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= '0;
      alu_op_q    <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      alu_op_q    <= alu_op_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
      illegal_q   <= illegal_d;
      retired_q   <= retired_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = ir_q;
  assign state       = state_q;
  assign illegal     = illegal_q;
  assign retired     = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: instructions are queued with their memory
// wait states and ALU results; a reference model pushes the expected
// per-instruction outcome, and a monitor pops and compares on every
// retirement.
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0040A183;
  localparam logic [31:0] I_SW   = 32'h0030A223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h008000EF;
  localparam logic [31:0] I_LUI  = 32'h123450B7;
  localparam logic [31:0] I_ADDI = 32'h40108093;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT ----------------
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack, rf_we, illegal;
  logic [31:0] imem_addr, imem_rdata, instruction, branch_target, pc, retired;
  logic [3:0]  alu_op, alu_op_q;
  logic        reg_write, mem_read, mem_write, branch, branch_taken;
  logic [2:0]  state;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction),
    .alu_op(alu_op), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .alu_op_q(alu_op_q),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .pc(pc), .state(state), .illegal(illegal), .retired(retired)
  );

  // Bench-side decoder driving the flag inputs from the IR.
  logic [6:0] dec_op;
  assign dec_op    = instruction[6:0];
  assign alu_op    = {instruction[30], instruction[14:12]};
  assign reg_write = (dec_op == OP_R) || (dec_op == OP_I) || (dec_op == OP_LOAD) ||
                     (dec_op == OP_LUI) || (dec_op == OP_JAL);
  assign mem_read  = (dec_op == OP_LOAD);
  assign mem_write = (dec_op == OP_STORE);
  assign branch    = (dec_op == OP_BR);

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- stimulus + expected queues ----------------
  logic [31:0] stim_ins_q[$], stim_iw_q[$], stim_dw_q[$], stim_tk_q[$], stim_tgt_q[$];
  logic [31:0] exp_pc_q[$], exp_ret_q[$], exp_cyc_q[$], exp_mask_q[$];
  logic [31:0] exp_rf_q[$], exp_mem_q[$], exp_we_q[$], exp_ins_q[$], exp_alu_q[$];

  logic [31:0] m_pc  = 32'h0;
  logic [31:0] m_ret = 32'h0;

  // Reference model: one queued instruction -> expected end state.
  task automatic add_instr(input logic [31:0] ins, input int iw, input int dw,
                           input logic tk, input logic [31:0] tgt);
    int cyc, rf, memc, wec;
    logic [31:0] mask;
    cyc = iw + 3; rf = 0; memc = 0; wec = 0;
    mask = 32'h0E;  // FETCH, DECODE, EXEC
    case (ins[6:0])
      OP_R, OP_I, OP_LUI: begin cyc += 1; rf = 1; mask |= 32'h20; m_pc += 4; end
      OP_LOAD: begin cyc += dw + 2; rf = 1; memc = dw + 1; mask |= 32'h30; m_pc += 4; end
      OP_STORE: begin cyc += dw + 1; memc = dw + 1; wec = dw + 1; mask |= 32'h10; m_pc += 4; end
      OP_BR: m_pc = tk ? tgt : m_pc + 32'd4;
      OP_JAL: begin cyc += 1; rf = 1; mask |= 32'h20; m_pc = tgt; end
      default: ;
    endcase
    m_ret += 1;
    stim_ins_q.push_back(ins); stim_iw_q.push_back(iw); stim_dw_q.push_back(dw);
    stim_tk_q.push_back({31'b0, tk}); stim_tgt_q.push_back(tgt);
    exp_pc_q.push_back(m_pc); exp_ret_q.push_back(m_ret); exp_cyc_q.push_back(cyc);
    exp_mask_q.push_back(mask); exp_rf_q.push_back(rf); exp_mem_q.push_back(memc);
    exp_we_q.push_back(wec); exp_ins_q.push_back(ins);
    exp_alu_q.push_back({28'b0, ins[30], ins[14:12]});
  endtask

  // ---------------- memory responders (drive at negedge) ----------------
  int icnt = 0, dcnt = 0, cur_dw = 0;
  initial begin
    imem_ack = 0; imem_rdata = 0; dmem_ack = 0; branch_taken = 0; branch_target = 0;
    forever begin
      @(negedge clk);
      if (imem_req && rst_n) begin
        if (stim_ins_q.size() > 0 && icnt >= int'(stim_iw_q[0])) begin
          imem_ack      = 1'b1;
          imem_rdata    = stim_ins_q.pop_front();
          void'(stim_iw_q.pop_front());
          cur_dw        = int'(stim_dw_q.pop_front());
          branch_taken  = stim_tk_q.pop_front() [0];
          branch_target = stim_tgt_q.pop_front();
          icnt          = 0;
        end else begin
          imem_ack   = 1'b0;
          imem_rdata = $urandom();
          if (stim_ins_q.size() > 0) icnt++;
        end
      end else begin
        // Stray acks and garbage data while no fetch is pending.
        imem_ack   = 1'($urandom_range(0, 1));
        imem_rdata = $urandom();
        icnt       = 0;
      end
      if (dmem_req) begin
        if (dcnt >= cur_dw) begin dmem_ack = 1'b1; dcnt = 0; end
        else begin dmem_ack = 1'b0; dcnt++; end
      end else begin
        dmem_ack = 1'($urandom_range(0, 1));
        dcnt     = 0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [31:0] last_ret = 0, cur_exp_pc = 0, smask = 0;
  int cyc = 0, rfc = 0, memc = 0, wec = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      last_ret = 0; cur_exp_pc = 0; smask = 0; cyc = 0; rfc = 0; memc = 0; wec = 0;
    end else begin
      if (retired !== last_ret) begin
        if (exp_pc_q.size() == 0) begin
          check("spurious_retire", retired, last_ret);
        end else begin
          cur_exp_pc = exp_pc_q.pop_front();
          check("pc",          pc,          cur_exp_pc);
          check("retired",     retired,     exp_ret_q.pop_front());
          check("cycles",      cyc,         exp_cyc_q.pop_front());
          check("state_set",   smask,       exp_mask_q.pop_front());
          check("rf_we_count", rfc,         exp_rf_q.pop_front());
          check("dmem_cycles", memc,        exp_mem_q.pop_front());
          check("dmem_we_cyc", wec,         exp_we_q.pop_front());
          check("ir",          instruction, exp_ins_q.pop_front());
          check("alu_op_q",    {28'b0, alu_op_q}, exp_alu_q.pop_front());
        end
        last_ret = retired;
        smask = 0; cyc = 0; rfc = 0; memc = 0; wec = 0;
      end
      if (state != 3'd0) begin
        cyc++;
        smask |= (32'd1 << state);
        rfc  += int'(rf_we);
        memc += int'(dmem_req);
        wec  += int'(dmem_we);
      end
      if (imem_req) check("imem_addr", imem_addr, cur_exp_pc);
    end
  end

  task automatic drain(input string tag);
    for (int i = 0; i < 5000 && exp_pc_q.size() > 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check(tag, exp_pc_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] list [7];
    logic [31:0] r;
    list = '{I_ADD, I_LW, I_SW, I_BEQ, I_JAL, I_LUI, I_ADDI};

    repeat (3) @(negedge clk);
    check("rst_state",   state,    3'd0);
    check("rst_pc",      pc,       32'h0);
    check("rst_ir",      instruction, 32'h0);
    check("rst_alu_op",  alu_op_q, 4'h0);
    check("rst_retired", retired,  32'h0);
    check("rst_illegal", illegal,  1'b0);
    check("rst_reqs",    {imem_req, dmem_req, dmem_we, rf_we}, 4'h0);

    add_instr(I_ADD,  0, 0, 1'b0, 32'h0);
    add_instr(I_LW,   0, 3, 1'b0, 32'h0);
    add_instr(I_SW,   0, 0, 1'b0, 32'h0);
    add_instr(I_BEQ,  0, 0, 1'b1, 32'h40);
    add_instr(I_BEQ,  0, 0, 1'b0, 32'h80);
    add_instr(I_JAL,  0, 0, 1'b0, 32'h100);
    add_instr(I_LUI,  2, 0, 1'b0, 32'h0);
    add_instr(I_SW,   1, 2, 1'b0, 32'h0);
    add_instr(I_BEQ,  0, 0, 1'b1, 32'hFFFF_FFFC);
    add_instr(I_ADDI, 0, 0, 1'b0, 32'h0);  // pc wraps to 0
    for (int k = 0; k < 24; k++) begin
      r = $urandom();
      r[1:0] = 2'b00;
      add_instr(list[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), r);
    end
    rst_n = 1'b1;
    drain("drain_main");

    // Illegal opcode: trap, sticky flag, no further fetches.
    stim_ins_q.push_back(I_BAD); stim_iw_q.push_back(0); stim_dw_q.push_back(0);
    stim_tk_q.push_back(0); stim_tgt_q.push_back(0);
    for (int i = 0; i < 50 && state != 3'd6; i++) @(negedge clk);
    check("trap_state",   state,    3'd6);
    check("trap_illegal", illegal,  1'b1);
    check("trap_pc",      pc,       m_pc);
    repeat (6) @(negedge clk);
    check("trap_stay",    state,    3'd6);
    check("trap_sticky",  illegal,  1'b1);
    check("trap_reqs",    {imem_req, dmem_req, rf_we}, 3'b000);
    check("trap_pc_hold", pc,       m_pc);
    check("trap_retired", retired,  m_ret);

    // Reset out of TRAP, then stall in FETCH and reset mid-handshake.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = 0; m_ret = 0;
    repeat (3) @(negedge clk);
    check("stall_fetch_req", {state, imem_req}, {3'd1, 1'b1});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state",   state,    3'd0);
    check("async_rst_pc",      pc,       32'h0);
    check("async_rst_illegal", illegal,  1'b0);
    check("async_rst_req",     imem_req, 1'b0);
    check("async_rst_retired", retired,  32'h0);
    repeat (2) @(negedge clk);
    add_instr(I_ADD, 0, 0, 1'b0, 32'h0);
    add_instr(I_LW,  0, 0, 1'b0, 32'h0);
    rst_n = 1'b1;
    drain("drain_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
